// File: rtl/vector_convergence_flagger_pkg.sv
// Shared definitions for the convergence flagger and the training-control FSM.
// The flag vector is one bit per element, bit i belonging to element i.
package vector_convergence_flagger_pkg;

  localparam int unsigned VCF_FLAG_W = 6;
  localparam int unsigned VCF_DATA_W = 16;

  typedef enum logic [1:0] {
    RESET_IDLE = 2'd0,
    COLLECT    = 2'd1,
    PUBLISH    = 2'd2
  } vcf_state_e;

  // Element index width; never below one bit so a single-element vector still has a counter.
  function automatic int unsigned vcf_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_convergence_flagger_abs_diff_compare.sv
// Combinational |cur - prev| < tolerance on signed elements.
// The difference is one bit wider than the data, so it cannot overflow.
module abs_diff_compare
  import vector_convergence_flagger_pkg::*;
#(
  parameter int unsigned data_width = VCF_DATA_W
) (
  input  logic [data_width-1:0] cur_data,
  input  logic [data_width-1:0] prev_data,
  input  logic [data_width-1:0] tolerance,
  output logic                  below_tol_c
);

  localparam int unsigned DIFF_W = data_width + 1;

  logic [DIFF_W-1:0] diff;
  logic [DIFF_W-1:0] mag;

  always_comb begin
    diff        = {cur_data[data_width-1], cur_data} - {prev_data[data_width-1], prev_data};
    mag         = diff[DIFF_W-1] ? (~diff + DIFF_W'(1)) : diff;
    below_tol_c = (mag < {1'b0, tolerance});
  end

endmodule

// File: rtl/vector_convergence_flagger.sv
// Compares each incoming iterate element with the previous iterate and publishes
// a per-element convergence flag vector with a one-cycle valid strobe.
module vector_convergence_flagger
  import vector_convergence_flagger_pkg::*;
#(
  parameter int unsigned size_of_data = VCF_FLAG_W,
  parameter int unsigned data_width   = VCF_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    training_mode,
  input  logic                    training_done,
  input  logic [data_width-1:0]   tolerance,
  input  logic                    elem_valid,
  input  logic [data_width-1:0]   elem_data,
  output logic                    elem_ready,
  output logic [size_of_data-1:0] flag_vectors_comparator,
  output logic                    flags_valid
);

  localparam int unsigned IDX_W = vcf_idx_w(size_of_data);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(size_of_data - 1);

  vcf_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    hist_q, hist_d;
  logic [size_of_data-1:0] shadow_q, shadow_d;
  logic [size_of_data-1:0] flags_q, flags_d;
  logic                    flags_valid_q, flags_valid_d;
  logic                    elem_ready_q, elem_ready_d;
  logic [data_width-1:0]   prev_q [size_of_data];
  logic [data_width-1:0]   prev_d [size_of_data];
  logic [data_width-1:0]   prev_cur;
  logic                    below_tol_c;
  logic                    transfer;

  assign prev_cur = prev_q[idx_q];

  abs_diff_compare #(.data_width(data_width)) u_cmp (
    .cur_data    (elem_data),
    .prev_data   (prev_cur),
    .tolerance   (tolerance),
    .below_tol_c (below_tol_c)
  );

  // Next-state and datapath; clears override the normal flow.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hist_d   = hist_q;
    shadow_d = shadow_q;
    flags_d  = flags_q;
    prev_d   = prev_q;
    transfer = elem_valid && elem_ready_q;

    if (training_done || !training_mode) begin
      state_d  = RESET_IDLE;
      idx_d    = '0;
      hist_d   = 1'b0;
      shadow_d = '0;
      flags_d  = '0;
    end else begin
      case (state_q)
        RESET_IDLE: begin
          state_d = COLLECT;
          idx_d   = '0;
          hist_d  = 1'b0;
        end
        COLLECT: begin
          if (transfer) begin
            prev_d[idx_q]   = elem_data;
            shadow_d[idx_q] = hist_q && below_tol_c;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              flags_d = shadow_d;
              state_d = PUBLISH;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        PUBLISH: begin
          hist_d   = 1'b1;
          shadow_d = '0;
          state_d  = COLLECT;
        end
        default: state_d = RESET_IDLE;
      endcase
    end

    elem_ready_d  = (state_d == COLLECT);
    flags_valid_d = (state_d == PUBLISH);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= RESET_IDLE;
      idx_q         <= '0;
      hist_q        <= 1'b0;
      shadow_q      <= '0;
      flags_q       <= '0;
      flags_valid_q <= 1'b0;
      elem_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hist_q        <= hist_d;
      shadow_q      <= shadow_d;
      flags_q       <= flags_d;
      flags_valid_q <= flags_valid_d;
      elem_ready_q  <= elem_ready_d;
    end
  end

  // History storage carries no reset; hist_q qualifies its use.
  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end

  assign elem_ready              = elem_ready_q;
  assign flag_vectors_comparator = flags_q;
  assign flags_valid             = flags_valid_q;

endmodule

// File: tb/tb_vector_convergence_flagger.sv
// Directed bench for vector_convergence_flagger (6 elements x 16 bits).
module tb_vector_convergence_flagger;

  logic        clk = 1'b0;
  logic        rst;
  logic        training_mode;
  logic        training_done;
  logic [15:0] tolerance;
  logic        elem_valid;
  logic [15:0] elem_data;
  logic        elem_ready;
  logic [5:0]  flag_vectors_comparator;
  logic        flags_valid;

  int checks   = 0;
  int failures = 0;

  logic [15:0] v1 [6];
  logic [15:0] v2 [6];
  logic [15:0] vx [6];

  vector_convergence_flagger #(.size_of_data(6), .data_width(16)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .training_mode           (training_mode),
    .training_done           (training_done),
    .tolerance               (tolerance),
    .elem_valid              (elem_valid),
    .elem_data               (elem_data),
    .elem_ready              (elem_ready),
    .flag_vectors_comparator (flag_vectors_comparator),
    .flags_valid             (flags_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sends the first n elements of v, idling 'gap' cycles after each transfer.
  // Returns on the negedge following the last transfer.
  task automatic send_elems(input logic [15:0] v [6], input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int cnt;
      elem_data  = v[i];
      elem_valid = 1'b1;
      cnt = 0;
      while (!elem_ready && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 20) check_eq("ready_timeout", 32'(elem_ready), 32'd1);
      @(negedge clk);
      elem_valid = 1'b0;
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check_eq("stall_no_valid", 32'(flags_valid), 32'd0);
        end
      end
    end
  endtask

  task automatic send_and_check(input string tag, input logic [15:0] v [6], input int gap,
                                input logic [5:0] exp_flags);
    send_elems(v, 6, gap);
    check_eq({tag, "_valid"}, 32'(flags_valid), 32'd1);
    check_eq({tag, "_flags"}, 32'(flag_vectors_comparator), 32'(exp_flags));
    @(negedge clk);
    check_eq({tag, "_valid_drop"}, 32'(flags_valid), 32'd0);
    check_eq({tag, "_flags_hold"}, 32'(flag_vectors_comparator), 32'(exp_flags));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v1 = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60};
    v2 = '{16'd12, 16'd20, 16'd26, 16'd40, 16'd57, 16'd63};

    rst = 1'b0; training_mode = 1'b1; training_done = 1'b0;
    tolerance = 16'd4; elem_valid = 1'b0; elem_data = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(elem_ready), 32'd0);
    check_eq("rst_flags", 32'(flag_vectors_comparator), 32'd0);
    check_eq("rst_valid", 32'(flags_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("ready_after_release", 32'(elem_ready), 32'd1);

    send_and_check("first_vec", v1, 0, 6'b000000);
    send_and_check("second_vec", v2, 0, 6'b101011);
    // Back to v1 at half rate: same distances as v1->v2.
    send_and_check("stall_vec", v1, 1, 6'b101011);

    tolerance = 16'd0;
    send_and_check("tol_zero", v1, 0, 6'b000000);

    tolerance = 16'hFFFF;
    vx = v1; vx[0] = 16'h8000;
    send_and_check("ext_min", vx, 0, 6'b111111);
    vx[0] = 16'h7FFF;
    send_and_check("ext_span_max", vx, 0, 6'b111110);
    vx[0] = 16'h8000;
    send_and_check("ext_back_min", vx, 0, 6'b111110);
    vx[0] = 16'h7FFE;
    send_and_check("ext_span_m1", vx, 0, 6'b111111);

    // training_done mid-vector clears flags and history.
    tolerance = 16'd4;
    send_elems(v1, 3, 0);
    training_done = 1'b1;
    @(negedge clk);
    training_done = 1'b0;
    check_eq("done_flags", 32'(flag_vectors_comparator), 32'd0);
    check_eq("done_valid", 32'(flags_valid), 32'd0);
    check_eq("done_ready", 32'(elem_ready), 32'd0);
    @(negedge clk);
    check_eq("done_valid_after", 32'(flags_valid), 32'd0);
    check_eq("done_ready_back", 32'(elem_ready), 32'd1);
    send_and_check("after_done", v1, 0, 6'b000000);
    send_and_check("hist_restored", v1, 0, 6'b111111);

    // Reset mid-vector followed by inference mode.
    send_elems(v2, 2, 0);
    rst = 1'b0; training_mode = 1'b0;
    @(negedge clk);
    check_eq("midrst_ready", 32'(elem_ready), 32'd0);
    check_eq("midrst_flags", 32'(flag_vectors_comparator), 32'd0);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("infer_ready", 32'(elem_ready), 32'd0);
      check_eq("infer_flags", 32'(flag_vectors_comparator), 32'd0);
      check_eq("infer_valid", 32'(flags_valid), 32'd0);
    end
    training_mode = 1'b1;
    @(negedge clk);
    check_eq("resume_ready", 32'(elem_ready), 32'd1);
    send_and_check("resume_first", v2, 0, 6'b000000);
    send_and_check("resume_second", v2, 0, 6'b111111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_convergence_flagger.md
# vector_convergence_flagger

Producer side of the comparator-flag interface consumed by the training-control FSM. Accepts successive solution/weight iterate vectors one element per cycle, compares each element against the same element of the previous iterate, and publishes a per-element convergence flag vector (`flag_vectors_comparator`) plus a one-cycle valid strobe. It sits between the update datapath (Adam/Manhattan step) and the FSM that decides `training_done`.

## Interface
- `size_of_data`, default 6: number of elements per vector; width of the flag vector.
- `data_width`, default 16: element width, signed two's complement fixed point.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset, synchronous and active-low (`rst == 0` resets on the next rising edge).
- `training_mode` input 1: 1 = accept vectors; 0 = inference, block idles and clears history.
- `training_done` input 1: from FSM; 1 clears history and flags at the next edge.
- `tolerance` input `data_width`: unsigned convergence threshold, sampled per element compare.
- `elem_valid` input 1: element present on `elem_data`.
- `elem_data` input `data_width`: signed element, presented in order index 0 … `size_of_data`-1.
- `elem_ready` output 1: block accepts an element this cycle.
- `flag_vectors_comparator` output `size_of_data`: bit i = 1 when element i converged.
- `flags_valid` output 1: one-cycle strobe, flag vector just updated.

## Operation
- States: RESET_IDLE, COLLECT, PUBLISH.
- RESET_IDLE: entered on reset, when `training_mode == 0`, or `training_done == 1`; `elem_ready = 0`; history_valid cleared; element index = 0. Leaves to COLLECT next cycle when `training_mode == 1` and `training_done == 0`.
- COLLECT: `elem_ready = 1`. Transfer = `elem_valid && elem_ready`. On transfer at index i:
  - diff = sign-extended `elem_data` − sign-extended prev[i], `data_width+1` bits (no overflow); mag = |diff|, `data_width+1` bits unsigned.
  - shadow flag[i] = history_valid && (mag < zero-extended `tolerance`) (strict less-than).
  - prev[i] ← `elem_data`; index increments.
  - Transfer at index `size_of_data`-1: index wraps to 0, state → PUBLISH.
- PUBLISH (exactly one cycle): `elem_ready = 0`; `flag_vectors_comparator` ← shadow flags; `flags_valid = 1`; history_valid ← 1; → COLLECT.
- First vector after any clear: all flags 0 (no history), vector stored as history.
- `tolerance == 0`: no element can converge; all flags 0.
- `flag_vectors_comparator` holds its value between PUBLISH cycles; never shows partial vectors.
- Priority per edge: reset > `training_done` > `training_mode == 0` > normal operation. A clear mid-vector discards partial shadow flags, clears index, history_valid, output flags, and `flags_valid`.
- `elem_valid` low in COLLECT: stall, no state change.

## Timing
- Reset values: `elem_ready = 0`, `flag_vectors_comparator = 0`, `flags_valid = 0`, index 0, history_valid 0; prev[] contents don't-care.
- After reset release with `training_mode == 1`: `elem_ready` rises after one edge.
- Throughput: one element per cycle; `size_of_data` + 1 cycles per vector at full rate (one PUBLISH bubble).
- Latency: flags and `flags_valid` visible the cycle after the last element is accepted.
- `flags_valid` never high two consecutive cycles.
- `training_done` clear: `flag_vectors_comparator` = 0 the cycle after it is sampled high.

## Structure
- Shared package: state encoding constants (RESET_IDLE, COLLECT, PUBLISH) and the flag-vector width convention shared with the FSM.
- One sub-module, `abs_diff_compare`: combinational signed subtract, absolute value, strict compare against tolerance; instantiated once and used on the current index.
- prev[] is a `size_of_data` × `data_width` register array indexed by the element counter.

## Test plan
- Reset, `size_of_data = 6`, `data_width = 16`, `tolerance = 4`: first vector {10,20,30,40,50,60} → `flags_valid` pulse, flags = 6'b000000.
- Second vector {12,20,26,40,57,63} → flags = 6'b101011 (|d| = 2,0,4,0,7,3; element 2 fails at exactly 4).
- Extremes: prev = −32768, new = 32767 with `tolerance = 16'hFFFF` → flag 0 (mag 65535 not < 65535), no overflow; new = 32766 → flag 1.
- `elem_valid` toggled every other cycle through a vector → same flags as full rate, `flags_valid` one cycle after sixth transfer.
- `training_done` pulsed after 3 elements of a vector → flags 0 next cycle, no `flags_valid`; next full vector gives all-zero flags (history cleared).
- `rst = 0` mid-vector, then `training_mode = 0` for 5 cycles → `elem_ready` stays 0, outputs 0; on `training_mode = 1` acceptance resumes at index 0.
